crc_gen_chk: RTL and testbench
==============================

CRC_GEN_CHK -- requirements
Module: crc_gen_chk

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the input beat width in bits; legal values are 8, 16, 32 and 64.
REQ-002 SHALL have parameter CRC_W, default 16, meaning the CRC width in bits; legal values are 16 and 32.
REQ-003 SHALL have parameter POLY, default 16'h1021, meaning the generator polynomial in normal form, CRC_W bits.
REQ-004 SHALL have parameter INIT, default all ones, meaning the register seed loaded at start of frame.
REQ-005 SHALL have parameter XOROUT, default 0, meaning the value XORed into the final CRC.
REQ-006 SHALL have parameter REFLECT, default 0; 1 bit-reflects each input byte and the final CRC.
REQ-007 SHALL have port iClk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-008 SHALL have port iRst_n, input, 1 bit, the asynchronous active-low reset.
REQ-009 SHALL have port iCrcEn, input, 1 bit, beat valid.
REQ-010 SHALL have port iSof, input, 1 bit, first beat of a frame; qualified by iCrcEn.
REQ-011 SHALL have port iEof, input, 1 bit, last beat of a frame; qualified by iCrcEn.
REQ-012 SHALL have port iData, input, DATA_W bits, beat data; the MSB byte is processed first.
REQ-013 SHALL have port iKeep, input, DATA_W/8 bits, byte enables; bit DATA_W/8-1 corresponds to the MSB byte.
REQ-014 SHALL have port oCrc, output, CRC_W bits, the final CRC, held until the next completion.
REQ-015 SHALL have port oCrcVld, output, 1 bit, a one-cycle pulse indicating that oCrc is updated.
REQ-016 SHALL have port oBusy, output, 1 bit, asserted while a frame is open.

Function
REQ-017 SHALL implement the states IDLE, RUN and DONE.
REQ-018 SHALL, in IDLE, leave the state unchanged on a beat without iSof (the beat is ignored); a beat with iSof loads INIT and folds in the beat, then goes to RUN, or to DONE if iEof is also set.
REQ-019 SHALL, in RUN, fold each beat into the register; a beat with iEof goes to DONE.
REQ-020 SHALL, in RUN, treat a beat with iSof as a restart: the open frame is discarded without an oCrcVld, the register is reseeded with INIT, and the beat is folded in.
REQ-021 SHALL, in DONE, last exactly one cycle: oCrcVld=1 and oCrc=final, then go to IDLE, or to RUN if the beat accepted in that cycle carries iSof without iEof.
REQ-022 SHALL, in DONE, pulse oCrcVld again in the following cycle when the beat accepted in that cycle carries both iSof and iEof.
REQ-023 SHALL apply final = reflect_if(REFLECT, reg) XOR XOROUT.
REQ-024 SHALL have a latency of one cycle from the iEof beat to oCrcVld and support back-to-back frames at full rate.
REQ-025 SHALL hold the register when iCrcEn=0, with no state change.
REQ-026 SHALL use iKeep only on the iEof beat; other beats are processed in full.
REQ-027 SHALL skip bytes whose iKeep bit is clear, while bytes with the bit set are folded in MSB-first order.
REQ-028 SHALL, when iKeep is all zero on the iEof beat, add no data and report final over the preceding bytes.
REQ-029 SHALL assert oBusy in RUN only.

Reset
REQ-030 SHALL, on iRst_n low, asynchronously force state IDLE, register=INIT, oCrc=0, oCrcVld=0 and oBusy=0.
REQ-031 SHALL, on reset mid-frame, abandon the frame with no oCrcVld, and accept a new iSof in the first cycle after release.

Configuration
REQ-032 SHALL compile in check mode when macro CRC_GEN_CHK_CHECK_EN is defined, adding input iExpCrc[CRC_W-1:0] sampled on the iEof beat and output oMatch.
REQ-033 SHALL, with CRC_GEN_CHK_CHECK_EN defined, drive oMatch=(final==iExpCrc) in the cycle oCrcVld=1 and clear it otherwise; oMatch resets to 0.
REQ-034 SHALL, with CRC_GEN_CHK_CHECK_EN undefined, have no iExpCrc, no oMatch and no compare logic.

Structure
REQ-035 SHALL place the state enum, the byte-reflect function and the named constants CRC16_CCITT_POLY=16'h1021 and CRC32_POLY=32'h04C11DB7 in shared package crc_pkg.
REQ-036 SHALL implement the per-byte combinational update (register, byte, POLY, REFLECT, giving the next register) as sub-module crc_byte_step, instantiated DATA_W/8 times in a chain with a keep-selected bypass per stage.

Verification
REQ-037 SHALL cover: DATA_W=32, CRC_W=16, INIT=FFFF, one frame of 3 beats 0x31323334, 0x35363738, 0x39000000 with keep=4'b1000 -> oCrc=0x29B1 and oCrcVld one cycle after the iEof beat.
REQ-038 SHALL cover: DATA_W=8, CRC_W=32, POLY=04C11DB7, INIT=FFFFFFFF, REFLECT=1, XOROUT=FFFFFFFF, input "123456789" -> 0xCBF43926.
REQ-039 SHALL cover: the REQ-037 frame with iCrcEn=0 gaps inserted randomly -> result unchanged at 0x29B1.
REQ-040 SHALL cover: iSof re-asserted mid-frame followed by the REQ-037 beats -> single pulse, 0x29B1; then a single iSof+iEof beat immediately in the DONE cycle -> two consecutive oCrcVld pulses.
REQ-041 SHALL cover: iRst_n asserted during the second beat -> outputs zero; then the full frame -> 0x29B1.
REQ-042 SHALL cover, with CRC_GEN_CHK_CHECK_EN defined: iExpCrc=0x29B1 -> oMatch=1; iExpCrc=0x29B0 -> oMatch=0.

Source files
------------

// File: rtl/crc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : crc_pkg
//  Description : Shared types and constants for the CRC generator/checker:
//                frame state encoding, standard polynomials and a byte
//                bit-reversal helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package crc_pkg;

    // Frame tracking states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } crcState_t;

    localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
    localparam logic [31:0] CRC32_POLY       = 32'h04C11DB7;

    // Mirror the bit order of one byte (bit 0 <-> bit 7)
    function automatic logic [7:0] reflectByte(input logic [7:0] b);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) begin
            r[k] = b[7-k];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/crc_byte_step.sv
`default_nettype none
// ============================================================================
//  Module      : crc_byte_step
//  Description : Combinational single-byte CRC update. Folds one byte into
//                the running register MSB-first using the normal-form
//                polynomial; the byte is bit-reversed first when REFLECT=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module crc_byte_step
    import crc_pkg::*;
#(
    parameter int               CRC_W   = 16,
    parameter logic [CRC_W-1:0] POLY    = CRC_W'(CRC16_CCITT_POLY),
    parameter int               REFLECT = 0
) (
    input  logic [CRC_W-1:0] iCrc,
    input  logic [7:0]       iByte,
    output logic [CRC_W-1:0] oCrc
);

    logic [7:0]       w_byte;
    logic [CRC_W-1:0] w_acc;

    // Align the byte with the register MSB, then do eight shift/XOR steps
    always_comb begin
        w_byte = (REFLECT != 0) ? reflectByte(iByte) : iByte;
        w_acc  = iCrc ^ {w_byte, {(CRC_W-8){1'b0}}};
        for (int k = 0; k < 8; k++) begin
            w_acc = w_acc[CRC_W-1] ? ((w_acc << 1) ^ POLY) : (w_acc << 1);
        end
        oCrc = w_acc;
    end

endmodule
`default_nettype wire

// File: rtl/crc_gen_chk.sv
`default_nettype none
// ============================================================================
//  Module      : crc_gen_chk
//  Description : Framed CRC generator/checker. Beats of DATA_W bits are
//                folded MSB byte first; iKeep trims bytes on the last beat.
//                The final CRC is presented one cycle after the iEof beat.
//                Optional check mode (macro CRC_GEN_CHK_CHECK_EN) compares
//                the final CRC against iExpCrc and drives oMatch.
//  Revision    : 1.0 - initial release
// ============================================================================
module crc_gen_chk
    import crc_pkg::*;
#(
    parameter int               DATA_W  = 32,
    parameter int               CRC_W   = 16,
    parameter logic [CRC_W-1:0] POLY    = CRC_W'(CRC16_CCITT_POLY),
    parameter logic [CRC_W-1:0] INIT    = {CRC_W{1'b1}},
    parameter logic [CRC_W-1:0] XOROUT  = '0,
    parameter int               REFLECT = 0
) (
    input  logic                iClk,
    input  logic                iRst_n,
    input  logic                iCrcEn,
    input  logic                iSof,
    input  logic                iEof,
    input  logic [DATA_W-1:0]   iData,
    input  logic [DATA_W/8-1:0] iKeep,
    output logic [CRC_W-1:0]    oCrc,
    output logic                oCrcVld,
    output logic                oBusy
`ifdef CRC_GEN_CHK_CHECK_EN
    ,
    input  logic [CRC_W-1:0]    iExpCrc,
    output logic                oMatch
`endif
);

    localparam int c_NBYTES = DATA_W / 8;

    crcState_t             r_state;
    logic [CRC_W-1:0]      r_crc;
    logic [CRC_W-1:0]      w_seed;
    logic [c_NBYTES-1:0]   w_keep;
    logic [CRC_W-1:0]      w_nextCrc;
    logic [CRC_W-1:0]      w_refl;
    logic [CRC_W-1:0]      w_final;
    logic                  w_accept;

    // A start-of-frame beat always restarts from the seed, even mid-frame
    assign w_seed   = iSof ? INIT : r_crc;
    // Byte enables only matter on the closing beat
    assign w_keep   = iEof ? iKeep : {c_NBYTES{1'b1}};
    // Beats outside an open frame are dropped unless they open one
    assign w_accept = iCrcEn && (iSof || (r_state == ST_RUN));

    // Byte chain: stage 0 handles the MSB byte; disabled bytes pass through
    for (genvar i = 0; i < c_NBYTES; i++) begin : g_byte
        logic [CRC_W-1:0] w_in;
        logic [CRC_W-1:0] w_step;
        logic [CRC_W-1:0] w_out;

        if (i == 0) begin : g_first
            assign w_in = w_seed;
        end else begin : g_next
            assign w_in = g_byte[i-1].w_out;
        end

        crc_byte_step #(
            .CRC_W   (CRC_W),
            .POLY    (POLY),
            .REFLECT (REFLECT)
        ) u_step (
            .iCrc  (w_in),
            .iByte (iData[DATA_W-1-8*i -: 8]),
            .oCrc  (w_step)
        );

        assign w_out = w_keep[c_NBYTES-1-i] ? w_step : w_in;
    end

    assign w_nextCrc = g_byte[c_NBYTES-1].w_out;

    // Full-width bit reversal of the register for reflected output
    always_comb begin
        w_refl = '0;
        for (int k = 0; k < CRC_W; k++) begin
            w_refl[k] = w_nextCrc[CRC_W-1-k];
        end
    end

    assign w_final = ((REFLECT != 0) ? w_refl : w_nextCrc) ^ XOROUT;

    // Frame FSM with registered result, pulse and busy outputs
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state <= ST_IDLE;
            r_crc   <= INIT;
            oCrc    <= '0;
            oCrcVld <= 1'b0;
            oBusy   <= 1'b0;
`ifdef CRC_GEN_CHK_CHECK_EN
            oMatch  <= 1'b0;
`endif
        end else begin
            oCrcVld <= 1'b0;
`ifdef CRC_GEN_CHK_CHECK_EN
            oMatch  <= 1'b0;
`endif
            if (w_accept) begin
                r_crc <= w_nextCrc;
                if (iEof) begin
                    r_state <= ST_DONE;
                    oCrcVld <= 1'b1;
                    oCrc    <= w_final;
                    oBusy   <= 1'b0;
`ifdef CRC_GEN_CHK_CHECK_EN
                    oMatch  <= (w_final == iExpCrc);
`endif
                end else begin
                    r_state <= ST_RUN;
                    oBusy   <= 1'b1;
                end
            end else if (r_state != ST_RUN) begin
                // DONE lasts one cycle; any unused encoding falls back to IDLE
                r_state <= ST_IDLE;
                oBusy   <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_crc_gen_chk.sv
`default_nettype none
// ============================================================================
//  Module      : tb_crc_gen_chk
//  Description : Scoreboard bench for crc_gen_chk. Two instances: a
//                CRC-16/CCITT-FALSE build on 32-bit beats and a CRC-32
//                (reflected) build on 8-bit beats. A frame-level model
//                collects accepted bytes and computes expected CRCs with
//                plain bit-serial arithmetic; monitors pop and compare.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_crc_gen_chk;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [31:0] crc;
        logic [31:0] expc;
        longint      t;
    } exp_t;

    logic        iClk;
    logic        rst_n;

    logic        en16, sof16, eof16;
    logic [31:0] data16;
    logic [3:0]  keep16;
    logic [15:0] crc16o;
    logic        vld16, busy16;

    logic        en32, sof32, eof32;
    logic [7:0]  data32;
    logic [0:0]  keep32;
    logic [31:0] crc32o;
    logic        vld32, busy32;

`ifdef CRC_GEN_CHK_CHECK_EN
    logic [15:0] exp16;
    logic [31:0] exp32;
    logic        match16, match32;
`endif

    int   nTests = 0;
    int   nFail  = 0;
    exp_t q16[$];
    exp_t q32[$];
    exp_t e16, e32;
    bq_t  list16, list32;
    bit   open16 = 1'b0;
    bit   open32 = 1'b0;

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    crc_gen_chk #(
        .DATA_W(32), .CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF),
        .XOROUT(16'h0000), .REFLECT(0)
    ) dut16 (
        .iClk(iClk), .iRst_n(rst_n), .iCrcEn(en16), .iSof(sof16), .iEof(eof16),
        .iData(data16), .iKeep(keep16), .oCrc(crc16o), .oCrcVld(vld16), .oBusy(busy16)
`ifdef CRC_GEN_CHK_CHECK_EN
        , .iExpCrc(exp16), .oMatch(match16)
`endif
    );

    crc_gen_chk #(
        .DATA_W(8), .CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
        .XOROUT(32'hFFFFFFFF), .REFLECT(1)
    ) dut32 (
        .iClk(iClk), .iRst_n(rst_n), .iCrcEn(en32), .iSof(sof32), .iEof(eof32),
        .iData(data32), .iKeep(keep32), .oCrc(crc32o), .oCrcVld(vld32), .oBusy(busy32)
`ifdef CRC_GEN_CHK_CHECK_EN
        , .iExpCrc(exp32), .oMatch(match32)
`endif
    );

    // ---------------- reference model ----------------
    function automatic logic [15:0] refCrc16(input bq_t q);
        logic [15:0] c = 16'hFFFF;
        logic        fb;
        foreach (q[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[15] ^ q[i][b];
                c  = c << 1;
                if (fb) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    function automatic logic [31:0] refCrc32(input bq_t q);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (q[i]) begin
            c = c ^ {24'h0, q[i]};
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nTests++;
        if (act !== req) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, act, req, $time);
        end
    endtask

    // ---------------- drivers (model updated at the sampling edge) ----------------
    task automatic beat16(input logic en, input logic sof, input logic eof,
                          input logic [31:0] d, input logic [3:0] k, input logic [15:0] expc);
        @(negedge iClk);
        en16 = en; sof16 = sof; eof16 = eof; data16 = d; keep16 = k;
`ifdef CRC_GEN_CHK_CHECK_EN
        exp16 = expc;
`endif
        @(posedge iClk);
        if (en && (sof || open16)) begin
            if (sof) list16.delete();
            for (int b = 3; b >= 0; b--) begin
                if (!eof || k[b]) list16.push_back(d[8*b +: 8]);
            end
            if (eof) begin
                q16.push_back('{crc: 32'(refCrc16(list16)), expc: 32'(expc),
                                t: longint'($time) + 5});
                open16 = 1'b0;
            end else begin
                open16 = 1'b1;
            end
        end
    endtask

    task automatic beat32(input logic en, input logic sof, input logic eof,
                          input logic [7:0] d, input logic k, input logic [31:0] expc);
        @(negedge iClk);
        en32 = en; sof32 = sof; eof32 = eof; data32 = d; keep32 = k;
`ifdef CRC_GEN_CHK_CHECK_EN
        exp32 = expc;
`endif
        @(posedge iClk);
        if (en && (sof || open32)) begin
            if (sof) list32.delete();
            if (!eof || k) list32.push_back(d);
            if (eof) begin
                q32.push_back('{crc: refCrc32(list32), expc: expc, t: longint'($time) + 5});
                open32 = 1'b0;
            end else begin
                open32 = 1'b1;
            end
        end
    endtask

    // Disabled beats carry random junk control/data that must be ignored
    task automatic idle16(input int n);
        for (int i = 0; i < n; i++)
            beat16(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom, 4'($urandom_range(0, 15)), 16'h0);
    endtask

    task automatic idle32(input int n);
        for (int i = 0; i < n; i++)
            beat32(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   8'($urandom), 1'($urandom_range(0, 1)), 32'h0);
    endtask

    // "123456789" frame on the 32-bit beat instance, optional random gaps
    task automatic gold16(input int maxGap, input logic [15:0] expc);
        idle16($urandom_range(0, maxGap));
        beat16(1'b1, 1'b1, 1'b0, 32'h31323334, 4'hF, expc);
        idle16($urandom_range(0, maxGap));
        beat16(1'b1, 1'b0, 1'b0, 32'h35363738, 4'hF, expc);
        idle16($urandom_range(0, maxGap));
        beat16(1'b1, 1'b0, 1'b1, 32'h39000000, 4'b1000, expc);
    endtask

    task automatic randFrame16;
        int n = $urandom_range(1, 4);
        if ($urandom_range(0, 3) == 0)
            beat16(1'b1, 1'b0, 1'($urandom_range(0, 1)), $urandom, 4'hF, 16'h0);
        for (int i = 0; i < n; i++) begin
            idle16($urandom_range(0, 1));
            beat16(1'b1, (i == 0), (i == n - 1), $urandom,
                   4'($urandom_range(0, 15)), 16'($urandom));
        end
    endtask

    task automatic randFrame32;
        int n = $urandom_range(1, 6);
        for (int i = 0; i < n; i++) begin
            idle32($urandom_range(0, 1));
            beat32(1'b1, (i == 0), (i == n - 1), 8'($urandom),
                   1'($urandom_range(0, 1)), $urandom);
        end
    endtask

    // ---------------- monitors ----------------
    // Compare every presented result against the oldest expectation
    always @(negedge iClk) begin
        if (rst_n === 1'b1) begin
            chk("busy16", 32'(busy16), 32'(open16));
            if (q16.size() > 0 && q16[0].t < longint'($time)) begin
                nTests++; nFail++;
                $display("FAIL missing16: no pulse, expected crc %h", q16[0].crc);
                void'(q16.pop_front());
            end
            if (vld16 === 1'b1) begin
                if (q16.size() == 0) begin
                    nTests++; nFail++;
                    $display("FAIL spurious16: pulse with crc %h, expected none", crc16o);
                end else begin
                    e16 = q16.pop_front();
                    chk("crc16", 32'(crc16o), e16.crc);
                    chk("lat16", 32'($time), 32'(e16.t));
`ifdef CRC_GEN_CHK_CHECK_EN
                    chk("match16", 32'(match16), 32'(e16.crc == e16.expc));
`endif
                end
            end
`ifdef CRC_GEN_CHK_CHECK_EN
            else chk("match16idle", 32'(match16), 32'd0);
`endif
        end
    end

    always @(negedge iClk) begin
        if (rst_n === 1'b1) begin
            chk("busy32", 32'(busy32), 32'(open32));
            if (q32.size() > 0 && q32[0].t < longint'($time)) begin
                nTests++; nFail++;
                $display("FAIL missing32: no pulse, expected crc %h", q32[0].crc);
                void'(q32.pop_front());
            end
            if (vld32 === 1'b1) begin
                if (q32.size() == 0) begin
                    nTests++; nFail++;
                    $display("FAIL spurious32: pulse with crc %h, expected none", crc32o);
                end else begin
                    e32 = q32.pop_front();
                    chk("crc32", crc32o, e32.crc);
                    chk("lat32", 32'($time), 32'(e32.t));
`ifdef CRC_GEN_CHK_CHECK_EN
                    chk("match32", 32'(match32), 32'(e32.crc == e32.expc));
`endif
                end
            end
`ifdef CRC_GEN_CHK_CHECK_EN
            else chk("match32idle", 32'(match32), 32'd0);
`endif
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] s [9];
        en16 = 0; sof16 = 0; eof16 = 0; data16 = 0; keep16 = 0;
        en32 = 0; sof32 = 0; eof32 = 0; data32 = 0; keep32 = 0;
`ifdef CRC_GEN_CHK_CHECK_EN
        exp16 = 0; exp32 = 0;
`endif
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_crc16", 32'(crc16o), 32'd0);
        chk("rst_vld16", 32'(vld16), 32'd0);
        chk("rst_busy16", 32'(busy16), 32'd0);
        chk("rst_crc32", crc32o, 32'd0);
        repeat (3) @(posedge iClk);
        #2 rst_n = 1'b1;

        // Known-answer frame, then with random disabled gaps
        gold16(0, 16'h29B1);
        idle16(2);
        chk("gold16", 32'(crc16o), 32'h000029B1);
        gold16(3, 16'h29B0);
        idle16(2);
        chk("gold16gap", 32'(crc16o), 32'h000029B1);

        // Restart mid-frame, then a one-beat frame in the DONE cycle
        beat16(1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 4'hF, 16'h0);
        beat16(1'b1, 1'b0, 1'b0, 32'h01020304, 4'hF, 16'h0);
        gold16(0, 16'h29B1);
        beat16(1'b1, 1'b1, 1'b1, 32'hA5A5A5A5, 4'b1100, 16'h1234);
        idle16(3);

        // Reset during the second beat abandons the frame
        beat16(1'b1, 1'b1, 1'b0, 32'h31323334, 4'hF, 16'h0);
        @(negedge iClk);
        en16 = 1'b1; sof16 = 1'b0; eof16 = 1'b0; data16 = 32'h35363738; keep16 = 4'hF;
        #2 rst_n = 1'b0;
        open16 = 1'b0;
        list16.delete();
        #1;
        chk("rstmid_crc16", 32'(crc16o), 32'd0);
        chk("rstmid_vld16", 32'(vld16), 32'd0);
        chk("rstmid_busy16", 32'(busy16), 32'd0);
        @(posedge iClk);
        #2 rst_n = 1'b1;
        gold16(0, 16'h29B1);
        idle16(2);
        chk("gold16rst", 32'(crc16o), 32'h000029B1);

        // Empty keep on the closing beat, including an empty single-beat frame
        beat16(1'b1, 1'b1, 1'b0, 32'h31323334, 4'hF, 16'h0);
        beat16(1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 4'b0000, 16'h0);
        beat16(1'b1, 1'b1, 1'b1, 32'h12345678, 4'b0000, 16'hFFFF);
        idle16(2);
        chk("empty16", 32'(crc16o), 32'h0000FFFF);

        for (int f = 0; f < 40; f++) randFrame16();
        idle16(3);

        // CRC-32 known answer over "123456789"
        for (int i = 0; i < 9; i++) s[i] = 8'h31 + 8'(i);
        for (int i = 0; i < 9; i++)
            beat32(1'b1, (i == 0), (i == 8), s[i], 1'b1, 32'hCBF43926);
        idle32(2);
        chk("gold32", crc32o, 32'hCBF43926);

        for (int f = 0; f < 30; f++) randFrame32();
        idle32(3);
        idle16(1);

        chk("drain16", 32'(q16.size()), 32'd0);
        chk("drain32", 32'(q32.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire
